yarp_writeback: RTL

Writeback stage for the yarp core: the single producer that drives the register file's one write port. It merges single-cycle ALU results with in-order, variable-latency load responses. It holds the destination register of each outstanding load in a small queue. It also publishes a register scoreboard so decode can stall on RAW/WAW hazards before reading the register file.

---
 rtl/yarp_writeback_if.sv | 45 ++++
 rtl/yarp_writeback.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/yarp_writeback_if.sv
// rtl/yarp_writeback_if.sv - writeback stage bundle: ALU, load issue/response, scoreboard and register-file write port
interface yarp_writeback_if #(
    parameter int XLEN     = 32,
    parameter int LD_DEPTH = 4
);
    localparam int CW = $clog2(LD_DEPTH) + 1;

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            ld_issue;
    logic [4:0]      ld_issue_rd;
    logic            ld_issue_ready;
    logic            ld_rsp_valid;
    logic [XLEN-1:0] ld_rsp_data;

    logic [4:0]      rs1_chk;
    logic [4:0]      rs2_chk;
    logic [4:0]      rd_chk;
    logic            hazard;

    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [CW-1:0]   ld_pending;
    logic            err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_issue_rd, ld_rsp_valid, ld_rsp_data,
        output rs1_chk, rs2_chk, rd_chk,
        input  alu_ready, ld_issue_ready, hazard,
        input  wr_en, wr_addr, wr_data, ld_pending, err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_issue_rd, ld_rsp_valid, ld_rsp_data,
        input  rs1_chk, rs2_chk, rd_chk,
        output alu_ready, ld_issue_ready, hazard,
        output wr_en, wr_addr, wr_data, ld_pending, err
    );
endinterface

// File: rtl/yarp_writeback.sv
// rtl/yarp_writeback.sv - register-file write port arbiter merging ALU results and in-order load responses
module yarp_writeback #(
    parameter int XLEN     = 32,
    parameter int LD_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    yarp_writeback_if.slave    wb
);
    localparam int PW = $clog2(LD_DEPTH);
    localparam int CW = PW + 1;

    // Load destination queue
    logic [LD_DEPTH-1:0][4:0] q_rd;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [CW-1:0]            count;
    logic [4:0]               head_rd;
    logic                     push;
    logic                     pop;
    logic [LD_DEPTH-1:0]      ent_valid;
    logic [PW-1:0]            ent_off [LD_DEPTH];

    // Skid for an ALU result displaced by a load response
    logic                     skid_full;
    logic [4:0]               skid_rd;
    logic [XLEN-1:0]          skid_data;
    logic                     skid_load;
    logic                     skid_drain;
    logic                     alu_acc;

    // Registered write port
    logic                     wr_en_q;
    logic [4:0]               wr_addr_q;
    logic [XLEN-1:0]          wr_data_q;
    logic                     nxt_en;
    logic [4:0]               nxt_addr;
    logic [XLEN-1:0]          nxt_data;
    logic                     err_q;

    assign head_rd = q_rd[rd_ptr];
    assign push    = wb.ld_issue && (count != CW'(LD_DEPTH));
    assign pop     = wb.ld_rsp_valid && (count != '0);
    assign alu_acc = wb.alu_valid && !skid_full;

    always_comb begin
        for (int i = 0; i < LD_DEPTH; i++) begin
            ent_off[i]   = PW'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, ent_off[i]} < count);
        end
    end

    // Port priority: load response, then skid, then a fresh ALU result
    always_comb begin
        nxt_en     = 1'b0;
        nxt_addr   = wr_addr_q;
        nxt_data   = wr_data_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        if (pop) begin
            nxt_en    = (head_rd != 5'd0);
            nxt_addr  = head_rd;
            nxt_data  = wb.ld_rsp_data;
            skid_load = alu_acc;
        end else if (skid_full) begin
            nxt_en     = (skid_rd != 5'd0);
            nxt_addr   = skid_rd;
            nxt_data   = skid_data;
            skid_drain = 1'b1;
        end else if (wb.alu_valid) begin
            nxt_en   = (wb.alu_rd != 5'd0);
            nxt_addr = wb.alu_rd;
            nxt_data = wb.alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr] <= wb.ld_issue_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            skid_full <= 1'b0;
            skid_rd   <= '0;
            skid_data <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);

            if (skid_drain) begin
                skid_full <= 1'b0;
            end else if (skid_load) begin
                skid_full <= 1'b1;
                skid_rd   <= wb.alu_rd;
                skid_data <= wb.alu_data;
            end

            wr_en_q   <= nxt_en;
            wr_addr_q <= nxt_addr;
            wr_data_q <= nxt_data;

            if (wb.ld_rsp_valid && (count == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    function automatic logic reg_busy(
        input logic [4:0]               r,
        input logic [LD_DEPTH-1:0][4:0] ents,
        input logic [LD_DEPTH-1:0]      vld,
        input logic                     sk_full,
        input logic [4:0]               sk_rd
    );
        logic b;
        b = sk_full && (sk_rd == r);
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (vld[i] && (ents[i] == r)) begin
                b = 1'b1;
            end
        end
        return b;
    endfunction

    // The in-flight write only matters for sources; rd is covered by queue and skid
    always_comb begin
        wb.hazard = 1'b0;
        if ((wb.rs1_chk != 5'd0) &&
            (reg_busy(wb.rs1_chk, q_rd, ent_valid, skid_full, skid_rd) ||
             (wr_en_q && (wr_addr_q == wb.rs1_chk)))) begin
            wb.hazard = 1'b1;
        end
        if ((wb.rs2_chk != 5'd0) &&
            (reg_busy(wb.rs2_chk, q_rd, ent_valid, skid_full, skid_rd) ||
             (wr_en_q && (wr_addr_q == wb.rs2_chk)))) begin
            wb.hazard = 1'b1;
        end
        if ((wb.rd_chk != 5'd0) &&
            reg_busy(wb.rd_chk, q_rd, ent_valid, skid_full, skid_rd)) begin
            wb.hazard = 1'b1;
        end
    end

    assign wb.alu_ready      = !skid_full;
    assign wb.ld_issue_ready = (count != CW'(LD_DEPTH));
    assign wb.ld_pending     = count;
    assign wb.wr_en          = wr_en_q;
    assign wb.wr_addr        = wr_addr_q;
    assign wb.wr_data        = wr_data_q;
    assign wb.err            = err_q;

endmodule
